// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline boundary: registered valid/ready handshake with a 2-entry skid buffer.
// ready_o_PC depends only on the state register, so decode stalls never reach the PC combinationally.
module if_id_skid_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter logic [31:0] RST_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_i_ROM,
   input  logic [31:0] pc_addr_i_ROM,
   input  logic        valid_i_ROM,
   output logic        ready_o_PC,
   input  logic        flush_i,
   input  logic        ready_i_ID,
   output logic [31:0] instr_o_ID,
   output logic [31:0] pc_addr_o_ID,
   output logic        valid_o_ID
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t      state, state_nxt;
   logic [31:0] main_instr, main_pc, skid_instr, skid_pc;
   logic [31:0] main_instr_nxt, main_pc_nxt, skid_instr_nxt, skid_pc_nxt;
   logic        in_fire, out_fire;

   assign ready_o_PC   = (state != FULL);
   assign valid_o_ID   = (state != EMPTY);
   assign instr_o_ID   = main_instr;
   assign pc_addr_o_ID = main_pc;

   assign in_fire  = valid_i_ROM & ready_o_PC;
   assign out_fire = valid_o_ID & ready_i_ID;

   always_comb begin
      state_nxt      = state;
      main_instr_nxt = main_instr;
      main_pc_nxt    = main_pc;
      skid_instr_nxt = skid_instr;
      skid_pc_nxt    = skid_pc;
      if (flush_i) begin
         state_nxt      = EMPTY;
         main_instr_nxt = NOP_INSTR;
         main_pc_nxt    = RST_PC;
         skid_instr_nxt = NOP_INSTR;
         skid_pc_nxt    = RST_PC;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt      = ONE;
                  main_instr_nxt = instr_i_ROM;
                  main_pc_nxt    = pc_addr_i_ROM;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_instr_nxt = instr_i_ROM;
                  main_pc_nxt    = pc_addr_i_ROM;
               end else if (in_fire) begin
                  state_nxt      = FULL;
                  skid_instr_nxt = instr_i_ROM;
                  skid_pc_nxt    = pc_addr_i_ROM;
               end else if (out_fire) begin
                  state_nxt      = EMPTY;
                  main_instr_nxt = NOP_INSTR;
                  main_pc_nxt    = RST_PC;
               end
            end
            FULL: begin
               // skid is the older pending entry, so it always moves into main before new input
               if (out_fire) begin
                  state_nxt      = ONE;
                  main_instr_nxt = skid_instr;
                  main_pc_nxt    = skid_pc;
                  skid_instr_nxt = NOP_INSTR;
                  skid_pc_nxt    = RST_PC;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         main_instr <= NOP_INSTR;
         main_pc    <= RST_PC;
         skid_instr <= NOP_INSTR;
         skid_pc    <= RST_PC;
      end else begin
         state      <= state_nxt;
         main_instr <= main_instr_nxt;
         main_pc    <= main_pc_nxt;
         skid_instr <= skid_instr_nxt;
         skid_pc    <= skid_pc_nxt;
      end
   end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios plus random traffic against a FIFO-queue model.
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_i_ROM = '0;
   logic [31:0] pc_addr_i_ROM = '0;
   logic        valid_i_ROM = 1'b0;
   logic        ready_o_PC;
   logic        flush_i = 1'b0;
   logic        ready_i_ID = 1'b0;
   logic [31:0] instr_o_ID;
   logic [31:0] pc_addr_o_ID;
   logic        valid_o_ID;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [63:0] q[$];
   logic [31:0] pc_ctr;

   if_id_skid_reg #(.NOP_INSTR(32'h0000_0013), .RST_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .instr_i_ROM(instr_i_ROM), .pc_addr_i_ROM(pc_addr_i_ROM), .valid_i_ROM(valid_i_ROM),
      .ready_o_PC(ready_o_PC), .flush_i(flush_i), .ready_i_ID(ready_i_ID),
      .instr_o_ID(instr_o_ID), .pc_addr_o_ID(pc_addr_o_ID), .valid_o_ID(valid_o_ID)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] e_instr, e_pc;
      e_instr = (q.size() > 0) ? q[0][63:32] : NOP;
      e_pc    = (q.size() > 0) ? q[0][31:0]  : 32'h0;
      check({tag, ".valid"}, {31'b0, valid_o_ID}, {31'b0, q.size() > 0});
      check({tag, ".ready"}, {31'b0, ready_o_PC}, {31'b0, q.size() < 2});
      check({tag, ".instr"}, instr_o_ID, e_instr);
      check({tag, ".pc"},    pc_addr_o_ID, e_pc);
   endtask

   // One clock: drive inputs, predict handshakes from the pre-edge queue, update model, compare.
   task automatic step(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic rdy, input logic fl);
      logic in_f, out_f;
      valid_i_ROM   = v;
      instr_i_ROM   = ins;
      pc_addr_i_ROM = pc;
      ready_i_ID    = rdy;
      flush_i       = fl;
      in_f  = v && (q.size() < 2);
      out_f = rdy && (q.size() > 0);
      @(posedge clk);
      #1;
      if (fl) q.delete();
      else begin
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back({ins, pc});
      end
      check_outputs(tag);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      q.delete();
      check_outputs("reset_async");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_outputs("reset_init");
      rst = 1'b0;

      // streaming A,B,C at pc 0,4,8
      step("stream", 1, 32'hA, 32'h0, 1, 0);
      step("stream", 1, 32'hB, 32'h4, 1, 0);
      step("stream", 1, 32'hC, 32'h8, 1, 0);
      step("stream", 0, 32'h0, 32'h0, 1, 0);
      step("stream", 0, 32'h0, 32'h0, 1, 0);

      // stall into FULL, then release
      step("skid", 1, 32'hA1, 32'h10, 0, 0);
      step("skid", 1, 32'hB1, 32'h14, 0, 0);
      step("skid", 1, 32'hC1, 32'h18, 0, 0);
      step("skid", 1, 32'hC1, 32'h18, 1, 0);
      step("skid", 1, 32'hD1, 32'h1C, 1, 0);
      step("skid", 0, 32'h0, 32'h0, 1, 0);
      step("skid", 0, 32'h0, 32'h0, 1, 0);
      step("skid", 0, 32'h0, 32'h0, 1, 0);

      // flush while FULL with C offered and decode accepting
      step("flush", 1, 32'hA2, 32'h20, 0, 0);
      step("flush", 1, 32'hB2, 32'h24, 0, 0);
      step("flush", 1, 32'hC2, 32'h28, 1, 1);
      step("flush", 1, 32'hF40, 32'h40, 1, 0);
      step("flush", 0, 32'h0, 32'h0, 1, 0);

      // sustained simultaneous in/out in ONE
      step("thru", 1, 32'h100, 32'h100, 1, 0);
      for (int i = 1; i <= 8; i++)
         step("thru", 1, 32'h100 + i, 32'h100 + 4 * i, 1, 0);

      // chip disabled: drain without spurious valid
      for (int i = 0; i < 4; i++) step("drain", 0, $urandom, $urandom, 1, 0);

      // reset mid-transfer
      step("prerst", 1, 32'h55, 32'h200, 0, 0);
      step("prerst", 1, 32'h66, 32'h204, 0, 0);
      async_reset();
      step("postrst", 0, 32'h0, 32'h0, 1, 0);

      // random traffic
      pc_ctr = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         logic v, r, f;
         v = ($urandom_range(3) != 0);
         r = ($urandom_range(2) != 0);
         f = ($urandom_range(15) == 0);
         step("rand", v, $urandom, pc_ctr, r, f);
         pc_ctr = pc_ctr + 4;
         if (i == 200) begin
            async_reset();
            step("rand_rst", 0, 32'h0, 32'h0, 1, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
